// File: rtl/desc_packer.sv
// Packs a stream of descriptor pixel bytes MSB-first into 32-bit words for the NCC
// descriptor loader. There is one output word register and one 4-byte pack accumulator.
module desc_packer #(
    parameter int PIXELS_PER_DESC = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        pix_ready,
    output logic [31:0] desc_data_in,
    output logic        desc_data_ready,
    input  logic        done_with_desc_data,
    output logic [3:0]  desc_row,
    output logic [1:0]  desc_col,
    output logic        busy,
    output logic        desc_done
);
    localparam int NWORDS = PIXELS_PER_DESC / 4;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [8:0]  byte_cnt;
    logic [1:0]  byte_pos;
    logic [5:0]  word_idx;
    logic [31:0] pack;
    logic        pack_full;
    logic [31:0] out_word;
    logic        out_valid;
    logic        done_q;

    logic        byte_xfer, word_xfer, last_word, out_free;
    logic [31:0] packed_word;

    always_comb begin
        state_nxt   = state;
        pix_ready   = 1'b0;
        byte_xfer   = 1'b0;
        word_xfer   = 1'b0;
        last_word   = 1'b0;
        out_free    = 1'b0;
        packed_word = {pack[23:0], pix_data};

        pix_ready = (state == RUN) && !pack_full && (byte_cnt < 9'(PIXELS_PER_DESC));
        byte_xfer = pix_valid && pix_ready;
        word_xfer = out_valid && done_with_desc_data;
        last_word = word_xfer && (word_idx == 6'(NWORDS - 1));
        // A word can enter the output register on the same edge the loader takes the old one.
        out_free  = !out_valid || word_xfer;

        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (last_word) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            byte_pos  <= '0;
            word_idx  <= '0;
            pack      <= '0;
            pack_full <= 1'b0;
            out_word  <= '0;
            out_valid <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= last_word;
            if (state == IDLE) begin
                if (start) begin
                    byte_cnt  <= '0;
                    byte_pos  <= '0;
                    word_idx  <= '0;
                    pack_full <= 1'b0;
                    out_valid <= 1'b0;
                end
            end else begin
                if (byte_xfer) begin
                    byte_cnt <= byte_cnt + 9'd1;
                    byte_pos <= byte_pos + 2'd1;
                    pack     <= packed_word;
                end
                if (word_xfer)
                    word_idx <= last_word ? 6'd0 : word_idx + 6'd1;

                if (byte_xfer && byte_pos == 2'd3) begin
                    // Completed word bypasses the accumulator when the output slot is free.
                    if (out_free) begin
                        out_word  <= packed_word;
                        out_valid <= 1'b1;
                    end else begin
                        pack_full <= 1'b1;
                    end
                end else if (pack_full && out_free) begin
                    out_word  <= pack;
                    out_valid <= 1'b1;
                    pack_full <= 1'b0;
                end else if (word_xfer) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    assign desc_data_in    = out_word;
    assign desc_data_ready = out_valid;
    assign desc_row        = word_idx[5:2];
    assign desc_col        = word_idx[1:0];
    assign busy            = (state == RUN);
    assign desc_done       = done_q;

endmodule

// File: tb/tb_desc_packer.sv
// Directed bench for desc_packer: the default 256-byte instance plus a 16-byte instance.
module tb_desc_packer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // 256-pixel instance
    logic        start = 0, pv = 0, ack = 0;
    logic [7:0]  pd = 0;
    logic        pr, drdy, busy, done;
    logic [31:0] dd;
    logic [3:0]  row;
    logic [1:0]  col;

    // 16-pixel instance
    logic        start_s = 0, pv_s = 0, ack_s = 0;
    logic [7:0]  pd_s = 0;
    logic        pr_s, drdy_s, busy_s, done_s;
    logic [31:0] dd_s;
    logic [3:0]  row_s;
    logic [1:0]  col_s;

    desc_packer dut (
        .clk(clk), .rst(rst), .start(start), .pix_valid(pv), .pix_data(pd),
        .pix_ready(pr), .desc_data_in(dd), .desc_data_ready(drdy),
        .done_with_desc_data(ack), .desc_row(row), .desc_col(col),
        .busy(busy), .desc_done(done)
    );

    desc_packer #(.PIXELS_PER_DESC(16)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .pix_valid(pv_s), .pix_data(pd_s),
        .pix_ready(pr_s), .desc_data_in(dd_s), .desc_data_ready(drdy_s),
        .done_with_desc_data(ack_s), .desc_row(row_s), .desc_col(col_s),
        .busy(busy_s), .desc_done(done_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; start = 0; pv = 0; ack = 0; start_s = 0; pv_s = 0; ack_s = 0;
        tick();
        rst = 0;
    endtask

    task automatic begin_desc();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({dd, drdy, row, col, pr, busy, done} !== 42'd0) begin
            fails++;
            $display("FAIL reset_outputs: got dd=%h rdy=%b row=%0d col=%0d pr=%b busy=%b done=%b, want all 0",
                     dd, drdy, row, col, pr, busy, done);
        end
        start = 1;
        #1;
        tests++;
        if (pr !== 1'b0) begin fails++; $display("FAIL ready_on_start: got %b want 0", pr); end
        tick();
        start = 0;
        tests++;
        if (busy !== 1'b1 || pr !== 1'b1) begin
            fails++; $display("FAIL run_entry: busy=%b pr=%b want 1 1", busy, pr);
        end
    endtask

    task automatic test_single();
        do_reset();
        begin_desc();
        ack = 1;
        for (int i = 0; i < 4; i++) begin
            pv = 1; pd = 8'(i + 1);
            tick();
        end
        pv = 0;
        tests++;
        if (drdy !== 1'b1 || dd !== 32'h01020304 || row !== 4'd0 || col !== 2'd0) begin
            fails++;
            $display("FAIL single_word: rdy=%b dd=%h row=%0d col=%0d want 1 01020304 0 0", drdy, dd, row, col);
        end
        tick();
        tests++;
        if (drdy !== 1'b0) begin fails++; $display("FAIL single_one_cycle: rdy=%b want 0", drdy); end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        int unstable = 0;
        logic seen = 0;
        logic [31:0] first = 0;
        do_reset();
        begin_desc();
        ack = 0; pv = 1; pd = 8'h10;
        for (int c = 0; c < 20; c++) begin
            if (pr) accepted++;
            tick();
            pd = 8'(8'h10 + accepted);
            if (drdy && !seen) begin seen = 1; first = dd; end
            else if (seen && dd !== first) unstable++;
        end
        tests++;
        if (accepted != 8 || pr !== 1'b0) begin
            fails++; $display("FAIL bp_accept: accepted=%0d pr=%b want 8 0", accepted, pr);
        end
        tests++;
        if (!seen || first !== 32'h10111213 || unstable != 0 || drdy !== 1'b1) begin
            fails++;
            $display("FAIL bp_hold: word=%h unstable=%0d rdy=%b want 10111213 0 1", first, unstable, drdy);
        end
        ack = 1;
        tick();
        ack = 0;
        tests++;
        if (drdy !== 1'b1 || dd !== 32'h14151617 || row !== 4'd0 || col !== 2'd1) begin
            fails++;
            $display("FAIL bp_second: rdy=%b dd=%h row=%0d col=%0d want 1 14151617 0 1", drdy, dd, row, col);
        end
        pv = 0;
    endtask

    task automatic test_full_desc();
        int nbytes = 0, nwords = 0, werr = 0, done_cnt = 0, busy_err = 0;
        logic [31:0] last_dd = 0;
        logic [5:0]  last_rc = 0;
        logic [31:0] exp_w;
        do_reset();
        begin_desc();
        pv = 1; ack = 1; pd = 0;
        for (int c = 0; c < 300; c++) begin
            logic bx, wx;
            bx = pv && pr;
            wx = drdy && ack;
            if (wx) begin
                exp_w = {8'(4*nwords), 8'(4*nwords+1), 8'(4*nwords+2), 8'(4*nwords+3)};
                if (dd !== exp_w || {row, col} !== 6'(nwords)) werr++;
                last_dd = dd; last_rc = {row, col};
                nwords++;
            end
            tick();
            if (bx) begin nbytes++; pd = 8'(nbytes); end
            if (done) begin done_cnt++; if (busy !== 1'b0) busy_err++; end
        end
        pv = 0; ack = 0;
        tests++;
        if (nwords != 64 || werr != 0 || nbytes != 256) begin
            fails++; $display("FAIL full_words: words=%0d errs=%0d bytes=%0d want 64 0 256", nwords, werr, nbytes);
        end
        tests++;
        if (last_dd !== 32'hFCFDFEFF || last_rc !== 6'd63) begin
            fails++; $display("FAIL full_last: dd=%h rowcol=%0d want fcfdfeff 63", last_dd, last_rc);
        end
        tests++;
        if (done_cnt != 1 || busy_err != 0 || busy !== 1'b0 || pr !== 1'b0) begin
            fails++;
            $display("FAIL full_done: pulses=%0d busy_err=%0d busy=%b pr=%b want 1 0 0 0", done_cnt, busy_err, busy, pr);
        end
    endtask

    task automatic test_reset_mid();
        int accepted = 0;
        int waited = 0;
        do_reset();
        begin_desc();
        pv = 1; ack = 1; pd = 8'hA0;
        while (accepted < 37 && waited < 200) begin
            if (pr) accepted++;
            tick();
            waited++;
            pd = 8'(8'hA0 + accepted);
        end
        rst = 1; start = 1;
        tick();
        rst = 0; start = 0; pv = 0; ack = 0;
        tests++;
        if (accepted != 37 || {dd, drdy, row, col, pr, busy, done} !== 42'd0) begin
            fails++;
            $display("FAIL mid_reset: acc=%0d dd=%h rdy=%b row=%0d col=%0d pr=%b busy=%b done=%b want 37 all 0",
                     accepted, dd, drdy, row, col, pr, busy, done);
        end
        begin_desc();
        for (int i = 0; i < 4; i++) begin
            pv = 1; pd = 8'(8'h55 + 8'h11 * i);
            tick();
        end
        pv = 0;
        tests++;
        if (drdy !== 1'b1 || dd !== 32'h55667788 || row !== 4'd0 || col !== 2'd0) begin
            fails++;
            $display("FAIL mid_restart: rdy=%b dd=%h row=%0d col=%0d want 1 55667788 0 0", drdy, dd, row, col);
        end
    endtask

    task automatic test_ignored_inputs();
        do_reset();
        begin_desc();
        for (int i = 0; i < 4; i++) begin
            pv = 1; pd = 8'(i + 1);
            ack = (i == 1);
            start = (i == 2);
            tick();
        end
        pv = 0; ack = 0; start = 0;
        tests++;
        if (drdy !== 1'b1 || dd !== 32'h01020304 || {row, col} !== 6'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL ignore_first: rdy=%b dd=%h row=%0d col=%0d busy=%b want 1 01020304 0 0 1",
                     drdy, dd, row, col, busy);
        end
        ack = 1;
        for (int i = 0; i < 4; i++) begin
            pv = 1; pd = 8'(i + 5);
            tick();
        end
        pv = 0;
        tests++;
        if (drdy !== 1'b1 || dd !== 32'h05060708 || row !== 4'd0 || col !== 2'd1) begin
            fails++;
            $display("FAIL ignore_second: rdy=%b dd=%h row=%0d col=%0d want 1 05060708 0 1", drdy, dd, row, col);
        end
        ack = 0;
    endtask

    task automatic test_small_random();
        int nbytes = 0, nwords = 0, werr = 0, rdy_err = 0, done_cnt = 0;
        logic [31:0] exp_w;
        do_reset();
        start_s = 1;
        tick();
        start_s = 0;
        pd_s = 8'h30;
        for (int c = 0; c < 400; c++) begin
            logic bx, wx;
            pv_s  = 1'($urandom_range(0, 1));
            ack_s = 1'($urandom_range(0, 1));
            #1;
            bx = pv_s && pr_s;
            wx = drdy_s && ack_s;
            if (nbytes >= 16 && pr_s) rdy_err++;
            if (wx) begin
                exp_w = {8'(8'h30 + 4*nwords), 8'(8'h31 + 4*nwords), 8'(8'h32 + 4*nwords), 8'(8'h33 + 4*nwords)};
                if (dd_s !== exp_w || {row_s, col_s} !== 6'(nwords)) werr++;
                nwords++;
            end
            tick();
            if (bx) begin nbytes++; pd_s = 8'(8'h30 + nbytes); end
            if (done_s) done_cnt++;
        end
        pv_s = 0; ack_s = 0;
        tests++;
        if (nwords != 4 || werr != 0 || nbytes != 16) begin
            fails++; $display("FAIL small_words: words=%0d errs=%0d bytes=%0d want 4 0 16", nwords, werr, nbytes);
        end
        tests++;
        if (rdy_err != 0 || done_cnt != 1 || busy_s !== 1'b0) begin
            fails++;
            $display("FAIL small_end: rdy_err=%0d pulses=%0d busy=%b want 0 1 0", rdy_err, done_cnt, busy_s);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_full_desc();
        test_reset_mid();
        test_ignored_inputs();
        test_small_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/desc_packer.md
DESC_PACKER -- requirements
Module: desc_packer

Interface
REQ-001 The block SHALL have parameter PIXELS_PER_DESC, default 256, meaning descriptor pixels (bytes) per descriptor; it SHALL be a multiple of 4 and at most 256.
REQ-002 The block SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port start  in  1  one-cycle request to begin a new descriptor.
REQ-005 The block SHALL have port pix_valid  in  1  upstream pixel byte valid.
REQ-006 The block SHALL have port pix_data  in  8  unsigned descriptor pixel.
REQ-007 The block SHALL have port pix_ready  out  1  block accepts pix_data this cycle.
REQ-008 The block SHALL have port desc_data_in  out  32  packed word to the NCC descriptor loader.
REQ-009 The block SHALL have port desc_data_ready  out  1  desc_data_in valid.
REQ-010 The block SHALL have port done_with_desc_data  in  1  loader acknowledge; consumes the presented word.
REQ-011 The block SHALL have port desc_row  out  4  PE row index of the presented word, equal to word_index[5:2].
REQ-012 The block SHALL have port desc_col  out  2  column group of the presented word, equal to word_index[1:0].
REQ-013 The block SHALL have port busy  out  1  a descriptor is in progress.
REQ-014 The block SHALL have port desc_done  out  1  one-cycle pulse, full descriptor delivered.

Function
REQ-015 Byte transfer SHALL occur on an edge where pix_valid and pix_ready are both high; word transfer SHALL occur on an edge where desc_data_ready and done_with_desc_data are both high.
REQ-016 Packing SHALL be MSB-first: byte k of a word (k=0..3 in arrival order) SHALL occupy bits [31-8k:24-8k].
REQ-017 The FSM SHALL have states IDLE and RUN: start in IDLE goes to RUN and clears all counters; the last word transfer goes to IDLE.
REQ-018 start SHALL be ignored in RUN; done_with_desc_data SHALL be ignored while desc_data_ready is low.
REQ-019 Storage SHALL be one output word register plus one pack register (4-byte accumulator with full flag).
REQ-020 When the 4th byte is accepted, the completed word SHALL load into the output register on that same edge if the output register is empty or transfers on that edge; otherwise it SHALL remain in the pack register with the full flag set.
REQ-021 A full pack register SHALL move to the output register on the first edge where the output register is empty or transfers.
REQ-022 pix_ready SHALL be high only in RUN, with pack register not full, and with fewer than PIXELS_PER_DESC bytes accepted; it SHALL be low in IDLE, including the cycle start is asserted.
REQ-023 desc_data_in, desc_row and desc_col SHALL be held stable while desc_data_ready is high and no transfer occurs.
REQ-024 With pix_valid and done_with_desc_data held high, throughput SHALL be one word per 4 cycles with no bubbles; first desc_data_ready SHALL rise in the cycle after the 4th byte is accepted.
REQ-025 The word index SHALL increment on each word transfer, from 0 to PIXELS_PER_DESC/4-1; it SHALL NOT wrap within a descriptor.
REQ-026 desc_done SHALL be high for exactly the one cycle after the final word transfer; busy SHALL be low in that cycle.
REQ-027 busy SHALL be high exactly while in RUN.

Reset
REQ-028 While rst is high on an edge, all state SHALL clear and outputs SHALL be 0 from the next cycle: desc_data_in, desc_data_ready, desc_row, desc_col, pix_ready, busy, desc_done.
REQ-029 Reset mid-descriptor SHALL discard any partial word and buffered word; the next start SHALL restart at row 0, col 0.
REQ-030 rst SHALL take priority over start and over simultaneous transfers on the same edge.

Verification
REQ-031 Scenario 1: start, then bytes 01,02,03,04 with ack high -> desc_data_in=0x01020304, row=0, col=0, desc_data_ready for exactly 1 cycle.
REQ-032 Scenario 2: ack low for 20 cycles, bytes streaming -> pix_ready low after 8 bytes accepted; desc_data_in stable at first word; after ack, second word is presented the next cycle.
REQ-033 Scenario 3: 256 bytes with value = index, ack always high -> 64 words, last word = 0xFCFDFEFF at row=15, col=3; desc_done pulses once; busy low in the same cycle.
REQ-034 Scenario 4: rst after 37 bytes accepted -> all outputs 0 next cycle; new descriptor's first word at row 0, col 0 carries only new bytes.
REQ-035 Scenario 5: start pulsed mid-descriptor, and ack pulsed while desc_data_ready is low -> word index and data unaffected.
REQ-036 Scenario 6: PIXELS_PER_DESC=16, random pix_valid and ack -> exactly 4 words in order; pix_ready low after 16 bytes.
